imod_ctl: RTL
=============

Name: imod_ctl

Overview:
- Sequences the instruction-modify (IMOD) path into the instruction register and arbitrates it against a debug/console instruction-injection port.
- Captures IMOD destination writes during write-back and accumulates them into a holding buffer.
- At the next fetch, drives the per-half select strobes and the substitute word presented to the IR load mux.
- Sits between destination decode / debug interface and the instruction register.

Parameters:
- IW, 48, width of the modifiable instruction word (IR bit 48 is not carried; the IR zeroes it when the high half is substituted).
- LOW, 26, width of the low half; high half is [IW-1:LOW].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- state_fetch  in  1  fetch cycle; IR loads at the end of this cycle
- state_write  in  1  write-back cycle; destination strobes are valid only when this is high
- dest_imod_lo  in  1  IMOD write to low half [LOW-1:0]
- dest_imod_hi  in  1  IMOD write to high half [IW-1:LOW]
- wdata  in  IW  write-back data
- imod_abort  in  1  discard pending IMOD (trap or aborted instruction)
- dbg_req  in  1  debug injection request (level)
- dbg_ir  in  IW  instruction to inject; sampled when the request is accepted
- dbg_ack  out  1  one-cycle pulse: injected word loaded into IR
- destimod0  out  1  IR low half takes iob
- destimod1  out  1  IR high half (and bit 48 = 0) takes iob
- iob  out  IW  substitute instruction word
- imod_pending  out  1  any IMOD half armed

Behaviour:
- All outputs are driven from registers only; no combinational path from any input to destimod0, destimod1 or iob. They are stable for the whole state_fetch cycle.
- Reset: imod_buf=0, pend_lo=0, pend_hi=0, dbg_buf=0, dbg state=IDLE, dbg_ack=0. Therefore destimod0=0, destimod1=0, iob=0, imod_pending=0.
- IMOD capture: on a clock edge with state_write=1:
  - dest_imod_lo → imod_buf[LOW-1:0] |= wdata[LOW-1:0], pend_lo=1.
  - dest_imod_hi → imod_buf[IW-1:LOW] |= wdata[IW-1:LOW], pend_hi=1.
  - Both strobes may be set together.
  - Repeated writes before a fetch OR-accumulate.
  - Strobes with state_write=0 are ignored.
- IMOD consume: at an edge with state_fetch=1 and debug not ARMED, clear pend_lo, pend_hi and imod_buf.
- state_write and state_fetch in the same cycle: consume first, then capture. The new write arms the following fetch and is never lost.
- imod_abort: clears pend_lo, pend_hi and imod_buf at that edge. It has priority over capture in the same cycle and does not affect debug state. Priority order is reset > imod_abort > capture/consume.
- Debug FSM:
  - IDLE: dbg_req=1 → latch dbg_buf=dbg_ir, go to ARMED.
  - ARMED: edge with state_fetch=1 → go to DONE; dbg_ack=1 for the next cycle only.
  - DONE: wait for dbg_req=0 → go to IDLE. A held dbg_req is never re-accepted.
- Output mux:
  - ARMED: destimod0=1, destimod1=1, iob=dbg_buf. Debug wins over IMOD.
  - Otherwise: destimod0=pend_lo, destimod1=pend_hi, iob=imod_buf.
- Pending IMOD while debug is ARMED is held, not consumed, and applies at the next fetch after the injection.
- imod_pending = pend_lo | pend_hi.
- Latency:
  - IMOD write to IR effect: next state_fetch, minimum 1 cycle after the write edge.
  - dbg_req to IR load: next state_fetch after acceptance.
  - dbg_ack asserts in the cycle after the IR loads.
- Reset mid-operation: an armed injection is dropped with no ack; the requester must deassert and re-request.

Test Plan:
- Reset, idle fetches → destimod0=destimod1=0, iob=0, dbg_ack never pulses.
- Write lo with wdata=0x000_0123_4567, then fetch → destimod0=1, destimod1=0, iob[25:0]=0x1234567 in the fetch cycle; all zero the cycle after.
- Two hi writes 0x8000_0000_0000 and 0x0400_0000_0000, then fetch → destimod1=1, iob[47:26] carries both bits (iob=0x8400_0000_0000).
- Write and fetch in the same cycle → current fetch sees no IMOD; next fetch sees destimod0=1 with the new data.
- IMOD lo pending plus dbg_req with dbg_ir=0xABCD_EF01_2345, then fetch → destimod0=destimod1=1, iob=0xABCDEF012345, dbg_ack one cycle later. Next fetch → destimod0=1 with the IMOD data. dbg_req held high → no second ack.
- Write hi, then imod_abort the same cycle as a second hi write → imod_pending=0, the next fetch has destimod1=0. Also: reset while ARMED → no dbg_ack, outputs zero.

Source files
------------

// File: rtl/imod_ctl.sv
// Purpose : sequences IMOD substitution into the IR and arbitrates it against debug instruction injection.
// Latency : IMOD write affects the next fetch (>=1 cycle); dbg_ack pulses the cycle after the IR loads the injected word.
// Backpress: none; a debug request is held ARMED until a fetch consumes it, and pending IMOD waits behind it.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   state_fetch           fetch cycle (IR loads at the end of it)
//   state_write           write-back cycle; qualifies dest_imod_lo/hi
//   dest_imod_lo/hi       IMOD writes into the low [LOW-1:0] / high [IW-1:LOW] half
//   wdata                 write-back data
//   imod_abort            discard any pending IMOD
//   dbg_req, dbg_ir       level request and word to inject
//   dbg_ack               one-cycle pulse after the injected word is loaded
//   destimod0/1, iob      per-half IR select strobes and substitute word (register-driven)
//   imod_pending          any IMOD half armed
module imod_ctl #(
  parameter int IW  = 48,
  parameter int LOW = 26
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          state_fetch,
  input  logic          state_write,
  input  logic          dest_imod_lo,
  input  logic          dest_imod_hi,
  input  logic [IW-1:0] wdata,
  input  logic          imod_abort,
  input  logic          dbg_req,
  input  logic [IW-1:0] dbg_ir,
  output logic          dbg_ack,
  output logic          destimod0,
  output logic          destimod1,
  output logic [IW-1:0] iob,
  output logic          imod_pending
);

  localparam logic [1:0] DBG_IDLE  = 2'd0;
  localparam logic [1:0] DBG_ARMED = 2'd1;
  localparam logic [1:0] DBG_DONE  = 2'd2;

  localparam logic [IW-1:0] LO_MASK = {{(IW-LOW){1'b0}}, {LOW{1'b1}}};
  localparam logic [IW-1:0] HI_MASK = ~LO_MASK;

  logic [IW-1:0] imod_buf_q, imod_buf_d;
  logic          pend_lo_q, pend_lo_d;
  logic          pend_hi_q, pend_hi_d;
  logic [IW-1:0] dbg_buf_q, dbg_buf_d;
  logic [1:0]    dbg_st_q, dbg_st_d;
  logic          dbg_ack_q, dbg_ack_d;

  logic dbg_armed;
  assign dbg_armed = (dbg_st_q == DBG_ARMED);

  // IMOD holding buffer. A fetch consumes before a same-cycle write is
  // captured, so the new write lands in the freshly cleared buffer and arms
  // the following fetch. While an injection is ARMED the fetch belongs to
  // debug, so pending IMOD is left in place.
  always_comb begin
    imod_buf_d = imod_buf_q;
    pend_lo_d  = pend_lo_q;
    pend_hi_d  = pend_hi_q;
    if (imod_abort) begin
      imod_buf_d = '0;
      pend_lo_d  = 1'b0;
      pend_hi_d  = 1'b0;
    end else begin
      if (state_fetch && !dbg_armed) begin
        imod_buf_d = '0;
        pend_lo_d  = 1'b0;
        pend_hi_d  = 1'b0;
      end
      if (state_write && dest_imod_lo) begin
        imod_buf_d = imod_buf_d | (wdata & LO_MASK);
        pend_lo_d  = 1'b1;
      end
      if (state_write && dest_imod_hi) begin
        imod_buf_d = imod_buf_d | (wdata & HI_MASK);
        pend_hi_d  = 1'b1;
      end
    end
  end

  // Debug injection FSM. DONE waits for the requester to drop dbg_req so a
  // held level is never taken as a second request.
  always_comb begin
    dbg_st_d  = dbg_st_q;
    dbg_buf_d = dbg_buf_q;
    dbg_ack_d = 1'b0;
    case (dbg_st_q)
      DBG_IDLE: begin
        if (dbg_req) begin
          dbg_buf_d = dbg_ir;
          dbg_st_d  = DBG_ARMED;
        end
      end
      DBG_ARMED: begin
        if (state_fetch) begin
          dbg_st_d  = DBG_DONE;
          dbg_ack_d = 1'b1;
        end
      end
      DBG_DONE: begin
        if (!dbg_req) dbg_st_d = DBG_IDLE;
      end
      default: dbg_st_d = DBG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imod_buf_q <= '0;
      pend_lo_q  <= 1'b0;
      pend_hi_q  <= 1'b0;
      dbg_buf_q  <= '0;
      dbg_st_q   <= DBG_IDLE;
      dbg_ack_q  <= 1'b0;
    end else begin
      imod_buf_q <= imod_buf_d;
      pend_lo_q  <= pend_lo_d;
      pend_hi_q  <= pend_hi_d;
      dbg_buf_q  <= dbg_buf_d;
      dbg_st_q   <= dbg_st_d;
      dbg_ack_q  <= dbg_ack_d;
    end
  end

  // Output mux selects between registers only, keyed by registered state,
  // so the IR load path sees values stable for the whole fetch cycle.
  assign destimod0    = dbg_armed | pend_lo_q;
  assign destimod1    = dbg_armed | pend_hi_q;
  assign iob          = dbg_armed ? dbg_buf_q : imod_buf_q;
  assign imod_pending = pend_lo_q | pend_hi_q;
  assign dbg_ack      = dbg_ack_q;

endmodule
